com_piso_serializer: RTL and testbench

Parallel-in/serial-out serializer with valid/ready handshakes on both sides. It does the opposite job to the codebase's serial delay lines: one wide word made of WORDS lanes goes in, and the lanes come out one WIDTH-bit beat at a time, with a last-beat marker. It sits between wide producers (line-buffer or window reads, PE result vectors) and narrow per-channel consumers in the accelerator datapath. It is fully backpressure-aware and sustains one input word every WORDS cycles with no bubbles.

---
 rtl/com_pkg.sv | 13 +
 rtl/com_piso_serializer.sv | 123 ++++++++++++
 tb/tb_com_piso_serializer.sv | 306 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/com_pkg.sv
// Shared definitions for the com_* serializer blocks: FSM state encoding and
// the beat-counter width helper.
package com_pkg;

  localparam logic S_IDLE  = 1'b0;
  localparam logic S_SHIFT = 1'b1;

  // Counter width for a beat index in 0..words-1; never narrower than 1 bit.
  function automatic int com_cnt_w(input int words);
    return (words <= 1) ? 1 : $clog2(words);
  endfunction

endpackage

// File: rtl/com_piso_serializer.sv
// Parallel-in/serial-out serializer. A WORDS-lane input word is loaded into a
// shift register and emitted one WIDTH-bit lane per output handshake, with
// out_last flagging the final lane. When the final beat transfers and a new
// word is offered, the word is reloaded in the same cycle so a continuous
// stream has no idle cycles between words.
module com_piso_serializer
  import com_pkg::*;
#(
  parameter int WIDTH     = 8,
  parameter int WORDS     = 4,
  parameter bit LSB_FIRST = 1'b1
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [WORDS*WIDTH-1:0] in_data,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [WIDTH-1:0]       out_data,
  output logic                   out_last,
  output logic                   busy
);

  localparam int CNT_W    = com_cnt_w(WORDS);
  localparam int SR_W     = WORDS * WIDTH;
  localparam int OUT_LANE = LSB_FIRST ? 0 : WORDS - 1;
  localparam logic [CNT_W-1:0] LAST_CNT  = CNT_W'(WORDS - 1);
  localparam logic             LOAD_LAST = (WORDS == 1);

  logic             r_state;
  logic             w_state_next;
  logic [SR_W-1:0]  r_sr;
  logic [SR_W-1:0]  w_sr_next;
  logic [SR_W-1:0]  w_sr_shift;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_cnt_next;
  logic [CNT_W-1:0] w_cnt_inc;
  logic             r_last;
  logic             w_last_next;
  logic             w_in_xfer;
  logic             w_out_xfer;

  // Shifted image of the register: every lane moves one step toward the
  // output lane and the far end fills with zeros.
  generate
    for (genvar gi = 0; gi < WORDS; gi++) begin : g_lane
      if (LSB_FIRST) begin : g_lsb
        if (gi == WORDS - 1) begin : g_fill
          assign w_sr_shift[gi*WIDTH +: WIDTH] = '0;
        end else begin : g_move
          assign w_sr_shift[gi*WIDTH +: WIDTH] = r_sr[(gi+1)*WIDTH +: WIDTH];
        end
      end else begin : g_msb
        if (gi == 0) begin : g_fill
          assign w_sr_shift[gi*WIDTH +: WIDTH] = '0;
        end else begin : g_move
          assign w_sr_shift[gi*WIDTH +: WIDTH] = r_sr[(gi-1)*WIDTH +: WIDTH];
        end
      end
    end
  endgenerate

  assign out_valid  = (r_state == S_SHIFT);
  assign busy       = (r_state == S_SHIFT);
  assign out_last   = r_last;
  assign out_data   = r_sr[OUT_LANE*WIDTH +: WIDTH];
  assign w_cnt_inc  = r_cnt + 1'b1;

  // Ready while idle, or when the final beat leaves this cycle (zero-bubble
  // reload). Held low during reset.
  assign in_ready   = rst_n && ((r_state == S_IDLE) ||
                                ((r_state == S_SHIFT) && r_last && out_ready));
  assign w_in_xfer  = in_valid && in_ready;
  assign w_out_xfer = out_valid && out_ready;

  // Next-state logic: load, shift, reload on the last beat, or return to idle.
  always_comb begin
    w_state_next = r_state;
    w_sr_next    = r_sr;
    w_cnt_next   = r_cnt;
    w_last_next  = r_last;
    if (r_state == S_IDLE) begin
      if (w_in_xfer) begin
        w_state_next = S_SHIFT;
        w_sr_next    = in_data;
        w_cnt_next   = '0;
        w_last_next  = LOAD_LAST;
      end
    end else begin
      if (w_out_xfer) begin
        if (!r_last) begin
          w_sr_next   = w_sr_shift;
          w_cnt_next  = w_cnt_inc;
          w_last_next = (w_cnt_inc == LAST_CNT);
        end else if (w_in_xfer) begin
          w_sr_next   = in_data;
          w_cnt_next  = '0;
          w_last_next = LOAD_LAST;
        end else begin
          w_state_next = S_IDLE;
          w_last_next  = 1'b0;
        end
      end
    end
  end

  // State, shift register and beat counter; reset discards any partial word.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_sr    <= '0;
      r_cnt   <= '0;
      r_last  <= 1'b0;
    end else begin
      r_state <= w_state_next;
      r_sr    <= w_sr_next;
      r_cnt   <= w_cnt_next;
      r_last  <= w_last_next;
    end
  end

endmodule

// File: tb/tb_com_piso_serializer.sv
// Self-checking bench for com_piso_serializer: directed scenarios on three
// configurations (LSB-first x4, MSB-first x4, single lane) plus a randomized
// run against a queue-based beat model.
module tb_com_piso_serializer;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Configuration A: WORDS=4, LSB first.
  logic        a_in_valid = 1'b0, a_in_ready, a_out_valid, a_out_ready = 1'b0;
  logic        a_out_last, a_busy;
  logic [31:0] a_in_data = '0;
  logic [7:0]  a_out_data;
  // Configuration B: WORDS=4, MSB first.
  logic        b_in_valid = 1'b0, b_in_ready, b_out_valid, b_out_ready = 1'b0;
  logic        b_out_last, b_busy;
  logic [31:0] b_in_data = '0;
  logic [7:0]  b_out_data;
  // Configuration C: WORDS=1.
  logic        c_in_valid = 1'b0, c_in_ready, c_out_valid, c_out_ready = 1'b0;
  logic        c_out_last, c_busy;
  logic [7:0]  c_in_data = '0;
  logic [7:0]  c_out_data;

  com_piso_serializer #(.WIDTH(8), .WORDS(4), .LSB_FIRST(1'b1)) u_a (
    .clk(clk), .rst_n(rst_n), .in_valid(a_in_valid), .in_ready(a_in_ready),
    .in_data(a_in_data), .out_valid(a_out_valid), .out_ready(a_out_ready),
    .out_data(a_out_data), .out_last(a_out_last), .busy(a_busy));

  com_piso_serializer #(.WIDTH(8), .WORDS(4), .LSB_FIRST(1'b0)) u_b (
    .clk(clk), .rst_n(rst_n), .in_valid(b_in_valid), .in_ready(b_in_ready),
    .in_data(b_in_data), .out_valid(b_out_valid), .out_ready(b_out_ready),
    .out_data(b_out_data), .out_last(b_out_last), .busy(b_busy));

  com_piso_serializer #(.WIDTH(8), .WORDS(1), .LSB_FIRST(1'b1)) u_c (
    .clk(clk), .rst_n(rst_n), .in_valid(c_in_valid), .in_ready(c_in_ready),
    .in_data(c_in_data), .out_valid(c_out_valid), .out_ready(c_out_ready),
    .out_data(c_out_data), .out_last(c_out_last), .busy(c_busy));

  typedef struct packed {
    logic [7:0] data;
    logic       last;
  } beat_t;

  task automatic test_reset();
    rst_n = 1'b0;
    #12;
    checks++;
    if ({a_out_valid, a_out_last, a_busy, a_in_ready, a_out_data} !== 12'h000) begin
      errors++;
      $display("FAIL reset_a: valid=%b last=%b busy=%b in_ready=%b data=%h, want all 0",
               a_out_valid, a_out_last, a_busy, a_in_ready, a_out_data);
    end
    checks++;
    if ({b_out_valid, b_out_last, b_busy, b_in_ready, b_out_data,
         c_out_valid, c_out_last, c_busy, c_in_ready, c_out_data} !== 24'h0) begin
      errors++;
      $display("FAIL reset_bc: b valid=%b in_ready=%b data=%h c valid=%b in_ready=%b data=%h, want 0",
               b_out_valid, b_in_ready, b_out_data, c_out_valid, c_in_ready, c_out_data);
    end
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    checks++;
    if (a_in_ready !== 1'b1 || a_out_valid !== 1'b0) begin
      errors++;
      $display("FAIL reset_release: in_ready=%b out_valid=%b, want 1/0", a_in_ready, a_out_valid);
    end
    $display("reset: done");
  endtask

  task automatic test_single_word();
    logic [7:0] exp_beat [4];
    exp_beat = '{8'h11, 8'h22, 8'h33, 8'h44};
    a_in_valid = 1'b1; a_in_data = 32'h44332211; a_out_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      a_in_valid = 1'b0;
      #1;
      checks++;
      if (a_out_valid !== 1'b1 || a_out_data !== exp_beat[k] || a_out_last !== (k == 3)) begin
        errors++;
        $display("FAIL single_beat%0d: valid=%b data=%h last=%b, want 1 %h %b",
                 k, a_out_valid, a_out_data, a_out_last, exp_beat[k], (k == 3));
      end
    end
    @(negedge clk);
    #1;
    checks++;
    if (a_out_valid !== 1'b0 || a_in_ready !== 1'b1 || a_busy !== 1'b0) begin
      errors++;
      $display("FAIL single_after: valid=%b in_ready=%b busy=%b, want 0 1 0",
               a_out_valid, a_in_ready, a_busy);
    end
    $display("single word 44332211: done");
  endtask

  task automatic test_back_to_back();
    a_in_valid = 1'b1; a_in_data = 32'h04030201; a_out_ready = 1'b1;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      if (k == 0) a_in_data = 32'h08070605;
      if (k == 4) a_in_valid = 1'b0;
      #1;
      checks++;
      if (a_out_valid !== 1'b1 || a_out_data !== 8'(k + 1) || a_out_last !== (k == 3 || k == 7)
          || a_in_ready !== (k == 3 || k == 7)) begin
        errors++;
        $display("FAIL b2b_beat%0d: valid=%b data=%h last=%b in_ready=%b, want 1 %h %b %b",
                 k, a_out_valid, a_out_data, a_out_last, a_in_ready, 8'(k + 1),
                 (k == 3 || k == 7), (k == 3 || k == 7));
      end
    end
    @(negedge clk);
    #1;
    checks++;
    if (a_out_valid !== 1'b0) begin
      errors++;
      $display("FAIL b2b_end: out_valid=%b, want 0", a_out_valid);
    end
    $display("back-to-back 04030201/08070605: done");
  endtask

  task automatic test_backpressure();
    a_in_valid = 1'b1; a_in_data = 32'h44332211; a_out_ready = 1'b1;
    @(negedge clk);
    a_in_valid = 1'b0;
    #1;
    checks++;
    if (a_out_data !== 8'h11) begin
      errors++;
      $display("FAIL bp_first: data=%h, want 11", a_out_data);
    end
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      a_out_ready = (i == 3);
      #1;
      checks++;
      if (a_out_valid !== 1'b1 || a_out_data !== 8'h22 || a_out_last !== 1'b0 || a_in_ready !== 1'b0) begin
        errors++;
        $display("FAIL bp_hold%0d: valid=%b data=%h last=%b in_ready=%b, want 1 22 0 0",
                 i, a_out_valid, a_out_data, a_out_last, a_in_ready);
      end
    end
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      #1;
      checks++;
      if (a_out_data !== 8'(8'h33 + 8'h11 * k) || a_out_last !== (k == 1)) begin
        errors++;
        $display("FAIL bp_resume%0d: data=%h last=%b, want %h %b",
                 k, a_out_data, a_out_last, 8'(8'h33 + 8'h11 * k), (k == 1));
      end
    end
    @(negedge clk);
    $display("backpressure on beat 22: done");
  endtask

  task automatic test_msb_first();
    logic [7:0] exp_beat [4];
    exp_beat = '{8'hAA, 8'hBB, 8'hCC, 8'hDD};
    b_in_valid = 1'b1; b_in_data = 32'hAABBCCDD; b_out_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      b_in_valid = 1'b0;
      #1;
      checks++;
      if (b_out_valid !== 1'b1 || b_out_data !== exp_beat[k] || b_out_last !== (k == 3)) begin
        errors++;
        $display("FAIL msb_beat%0d: valid=%b data=%h last=%b, want 1 %h %b",
                 k, b_out_valid, b_out_data, b_out_last, exp_beat[k], (k == 3));
      end
    end
    @(negedge clk);
    $display("MSB-first AABBCCDD: done");
  endtask

  task automatic test_single_lane();
    c_in_valid = 1'b1; c_in_data = 8'h5A; c_out_ready = 1'b1;
    @(negedge clk);
    c_in_data = 8'hA5;
    #1;
    checks++;
    if (c_out_valid !== 1'b1 || c_out_data !== 8'h5A || c_out_last !== 1'b1 || c_in_ready !== 1'b1) begin
      errors++;
      $display("FAIL lane1_5a: valid=%b data=%h last=%b in_ready=%b, want 1 5a 1 1",
               c_out_valid, c_out_data, c_out_last, c_in_ready);
    end
    @(negedge clk);
    c_in_valid = 1'b0;
    #1;
    checks++;
    if (c_out_valid !== 1'b1 || c_out_data !== 8'hA5 || c_out_last !== 1'b1) begin
      errors++;
      $display("FAIL lane1_a5: valid=%b data=%h last=%b, want 1 a5 1",
               c_out_valid, c_out_data, c_out_last);
    end
    @(negedge clk);
    #1;
    checks++;
    if (c_out_valid !== 1'b0 || c_busy !== 1'b0) begin
      errors++;
      $display("FAIL lane1_idle: valid=%b busy=%b, want 0 0", c_out_valid, c_busy);
    end
    $display("WORDS=1 stream 5A,A5: done");
  endtask

  task automatic test_reset_mid_word();
    logic [7:0] exp_beat [4];
    exp_beat = '{8'hEF, 8'hBE, 8'hAD, 8'hDE};
    a_in_valid = 1'b1; a_in_data = 32'h44332211; a_out_ready = 1'b1;
    @(negedge clk);
    a_in_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if (a_out_valid !== 1'b0 || a_out_data !== 8'h00 || a_busy !== 1'b0 || a_in_ready !== 1'b0) begin
      errors++;
      $display("FAIL midreset_async: valid=%b data=%h busy=%b in_ready=%b, want 0 00 0 0",
               a_out_valid, a_out_data, a_busy, a_in_ready);
    end
    @(negedge clk);
    rst_n = 1'b1;
    a_in_valid = 1'b1; a_in_data = 32'hDEADBEEF;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      a_in_valid = 1'b0;
      #1;
      checks++;
      if (a_out_valid !== 1'b1 || a_out_data !== exp_beat[k] || a_out_last !== (k == 3)) begin
        errors++;
        $display("FAIL midreset_beat%0d: valid=%b data=%h last=%b, want 1 %h %b",
                 k, a_out_valid, a_out_data, a_out_last, exp_beat[k], (k == 3));
      end
    end
    @(negedge clk);
    $display("reset mid-word then DEADBEEF: done");
  endtask

  // Model: a queue of pending beats. out_valid means the queue is non-empty;
  // a new word is only taken when nothing, or only the final beat being
  // consumed right now, is pending.
  task automatic test_random();
    beat_t q[$];
    logic  exp_ready, iv, orr;
    logic [31:0] d;
    int    words_in = 0, beats_out = 0, errs_before;
    errs_before = errors;
    for (int cyc = 0; cyc < 400; cyc++) begin
      @(negedge clk);
      iv  = ($urandom_range(0, 3) != 0);
      orr = ($urandom_range(0, 3) != 0);
      d   = $urandom;
      a_in_valid = iv; a_in_data = d; a_out_ready = orr;
      #1;
      exp_ready = (q.size() == 0) || (q.size() == 1 && orr);
      checks++;
      if (a_out_valid !== (q.size() != 0) || a_busy !== (q.size() != 0) || a_in_ready !== exp_ready) begin
        errors++;
        $display("FAIL rand_ctrl cyc%0d: valid=%b busy=%b in_ready=%b, want %b %b %b",
                 cyc, a_out_valid, a_busy, a_in_ready, (q.size() != 0), (q.size() != 0), exp_ready);
      end
      if (q.size() != 0) begin
        checks++;
        if (a_out_data !== q[0].data || a_out_last !== q[0].last) begin
          errors++;
          $display("FAIL rand_beat cyc%0d: data=%h last=%b, want %h %b",
                   cyc, a_out_data, a_out_last, q[0].data, q[0].last);
        end
        if (orr) begin
          void'(q.pop_front());
          beats_out++;
        end
      end
      if (iv && exp_ready) begin
        for (int k = 0; k < 4; k++) q.push_back('{data: d[8*k +: 8], last: (k == 3)});
        words_in++;
      end
    end
    a_in_valid = 1'b0; a_out_ready = 1'b1;
    for (int i = 0; i < 8; i++) @(negedge clk);
    $display("random: %0d words in, %0d beats checked, %0d new errors",
             words_in, beats_out, errors - errs_before);
  endtask

  initial begin
    test_reset();
    test_single_word();
    test_back_to_back();
    test_backpressure();
    test_msb_first();
    test_single_lane();
    test_reset_mid_word();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
